sram_bank_sched: RTL
====================

Name: sram_bank_sched

Overview:
- Phase-sequenced controller and two-requester arbiter for the 2-port SRAM bank (sram_array).
- Divides time into slots of PHASES clk cycles, one bank transaction per slot.
- Grants one requester per slot, then drives the array in fixed phase order: one-hot word lines at ph2, data at ph4, ReadEn at ph6, WriteEn at ph8.
- Captures read data and returns it to the granted requester.

Parameters:
WIDTH, 16, data word width
WORDS, 32, rows in array; width of one-hot word-line buses
ADDR_BITS, 5, binary row address width (= clog2(WORDS))
PHASES, 10, clk cycles per slot; legal values >= 10

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high
req  in  2  request per requester i; held high until gnt[i]
we  in  2  1 = write, 0 = read; sampled with gnt
addr_a  in  2*ADDR_BITS  port-A row, requester i at [i*ADDR_BITS +: ADDR_BITS]
addr_b  in  2*ADDR_BITS  port-B row, same packing
en_a  in  2  enable port-A word line for requester i
en_b  in  2  enable port-B word line for requester i
wdata  in  2*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
gnt  out  2  1-cycle grant pulse; request fields captured this cycle
rvalid  out  2  1-cycle pulse; rdata_a/rdata_b valid for that requester
rdata_a  out  WIDTH  captured outA, held until next capture
rdata_b  out  WIDTH  captured outB, held until next capture
wordA  out  WORDS  one-hot port-A word lines to array
wordB  out  WORDS  one-hot port-B word lines to array
ReadEn  out  1  array read enable
WriteEn  out  1  array write enable
din  out  WIDTH  array write data
outA  in  WIDTH  array port-A read data
outB  in  WIDTH  array port-B read data
phase  out  4  current phase 0..PHASES-1
busy  out  1  slot holds a granted transaction

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset.
- Reset values: phase=0, busy=0, gnt=0, rvalid=0, rdata_a/b=0, wordA/B=0, ReadEn=0, WriteEn=0, din=0, rr pointer=1 (requester 0 wins first contest).
- Phase counter: free-runs 0..PHASES-1 and wraps to 0. All outputs are registered; "at phK" means the value is visible while phase==K.
- ph0 arbitration: grant one of req[1:0] combinationally from inputs and registered into gnt at ph0 (pulse only during ph0).
  - Both requesting: grant the requester not granted last (round-robin); rr pointer updates on each grant.
  - Winner's we/addr/en/wdata latched into slot registers; busy=1 from ph0 to PHASES-1.
  - No request: busy=0; no array signals asserted in that slot.
  - A req arriving after ph0 waits for the next slot.
- ph2 through PHASES-1: wordA = en_a ? (1<<addr_a) : 0; wordB likewise. Exactly one bit set or all zero. Both cleared at ph0.
- ph4 through PHASES-1: din = latched wdata on writes; din = 0 on reads.
- Read: ReadEn=1 during ph6 and ph7. At end of ph7, outA/outB are sampled into rdata_a/rdata_b, and rvalid[i] pulses during ph8.
- Write: WriteEn=1 during ph8 only. No rvalid.
- ReadEn and WriteEn are never high in the same cycle.
- Write with addr_a==addr_b and both enabled is legal: one row, both lines target it.
- Both en bits 0: slot still consumed, grant and rvalid still issued, word lines stay 0.
- Reset mid-slot: everything returns to reset values next cycle. In-flight transaction is dropped (no rvalid); requester re-requests.
- Extra phases when PHASES > 10: hold ph9 output state, with ReadEn and WriteEn low.

Test Plan:
- Single write: req[0], we=1, addr_a=1, addr_b=2, en=11, wdata=AAAA → gnt[0] at ph0, wordA=0x2 and wordB=0x4 from ph2, din=AAAA from ph4, WriteEn only at ph8; array rows 1 and 2 hold AAAA.
- Read back: req[1], we=0, addr_a=1, addr_b=2 → ReadEn ph6-7, rvalid[1] at ph8, rdata_a=rdata_b=AAAA, din=0.
- Contention: req=11 held across 4 slots → grants alternate 0,1,0,1; never both in one slot.
- Disabled port: write ABCD, addr_a=5, en_a=0, en_b=1, addr_b=3 → wordA stays 0, wordB=0x8; only row 3 becomes ABCD.
- Idle and late request: req rises at ph3 → no array activity this slot, gnt at the next ph0, busy=0 in the idle slot.
- Reset at ph7 of a read → all outputs 0 next cycle, phase=0, no rvalid, next slot regrants the still-held req.

Source files
------------

// File: rtl/sram_bank_sched_if.sv
// Requester-side bus of the SRAM bank scheduler. Two requesters share it;
// every per-requester field is packed with requester i in slice i.
//
// Handshake: requester i raises req[i] together with we/addr/en/wdata and
// holds all of them stable until it sees gnt[i]. gnt[i] is a one-cycle
// pulse (during phase 0) and marks the cycle in which the fields have
// already been captured, so the requester may change or drop them from the
// next cycle on. A read later returns exactly one rvalid[i] pulse; rdata_a
// and rdata_b are valid during that pulse and held until the next read
// capture. Writes return no rvalid.
interface sram_bank_sched_if #(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 5
);
  logic [1:0]             req;
  logic [1:0]             we;
  logic [2*ADDR_BITS-1:0] addr_a;
  logic [2*ADDR_BITS-1:0] addr_b;
  logic [1:0]             en_a;
  logic [1:0]             en_b;
  logic [2*WIDTH-1:0]     wdata;
  logic [1:0]             gnt;
  logic [1:0]             rvalid;
  logic [WIDTH-1:0]       rdata_a;
  logic [WIDTH-1:0]       rdata_b;

  modport master (
    output req, we, addr_a, addr_b, en_a, en_b, wdata,
    input  gnt, rvalid, rdata_a, rdata_b
  );

  modport slave (
    input  req, we, addr_a, addr_b, en_a, en_b, wdata,
    output gnt, rvalid, rdata_a, rdata_b
  );
endinterface

// File: rtl/sram_bank_sched.sv
// Phase-sequenced controller and two-requester round-robin arbiter for a
// 2-port SRAM bank. Time is cut into slots of PHASES cycles; one granted
// transaction per slot drives word lines, data and enables in fixed order.
// Every output is registered from the next-phase value, so "at phK" means
// the output is visible while phase_o == K.
module sram_bank_sched #(
  parameter int WIDTH     = 16,
  parameter int WORDS     = 32,
  parameter int ADDR_BITS = 5,
  parameter int PHASES    = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_bank_sched_if.slave     req_if,
  output logic [WORDS-1:0]     wordA_o,
  output logic [WORDS-1:0]     wordB_o,
  output logic                 ReadEn_o,
  output logic                 WriteEn_o,
  output logic [WIDTH-1:0]     din_o,
  input  logic [WIDTH-1:0]     outA_i,
  input  logic [WIDTH-1:0]     outB_i,
  output logic [3:0]           phase_o,
  output logic                 busy_o
);

  localparam logic [3:0] LAST_PH = 4'(PHASES - 1);

  // Phase counter and its next value; phase_q is also the exposed sequencer state.
  logic [3:0]           phase_q, phase_d;
  logic                 busy_q;
  logic                 rr_q;          // requester granted most recently
  logic [1:0]           gnt_q, rvalid_q;
  logic [WORDS-1:0]     word_a_q, word_b_q;
  logic                 read_en_q, write_en_q;
  logic [WIDTH-1:0]     din_q, rdata_a_q, rdata_b_q;

  // Slot registers: the winning request, frozen for the whole slot.
  logic                 slot_id_q, slot_we_q, slot_en_a_q, slot_en_b_q;
  logic [ADDR_BITS-1:0] slot_addr_a_q, slot_addr_b_q;
  logic [WIDTH-1:0]     slot_wdata_q;

  // Arbitration result from the live request inputs.
  logic                 win_valid, win_id;

  // Next phase: free-running modulo PHASES.
  always_comb begin
    phase_d = (phase_q == LAST_PH) ? 4'd0 : phase_q + 4'd1;
  end

  // Round-robin pick: on contention the requester not granted last wins.
  always_comb begin
    win_valid = |req_if.req;
    if (req_if.req == 2'b11) win_id = ~rr_q;
    else                     win_id = req_if.req[1];
  end

  // Slot sequencer: grant/latch entering ph0, then array phases in order.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= '0;
      busy_q        <= 1'b0;
      rr_q          <= 1'b1;
      gnt_q         <= '0;
      rvalid_q      <= '0;
      word_a_q      <= '0;
      word_b_q      <= '0;
      read_en_q     <= 1'b0;
      write_en_q    <= 1'b0;
      din_q         <= '0;
      rdata_a_q     <= '0;
      rdata_b_q     <= '0;
      slot_id_q     <= 1'b0;
      slot_we_q     <= 1'b0;
      slot_en_a_q   <= 1'b0;
      slot_en_b_q   <= 1'b0;
      slot_addr_a_q <= '0;
      slot_addr_b_q <= '0;
      slot_wdata_q  <= '0;
    end else begin
      phase_q    <= phase_d;
      gnt_q      <= '0;
      rvalid_q   <= '0;
      read_en_q  <= 1'b0;
      write_en_q <= 1'b0;

      if (phase_d == 4'd0) begin
        busy_q   <= win_valid;
        word_a_q <= '0;
        word_b_q <= '0;
        din_q    <= '0;
        if (win_valid) begin
          gnt_q         <= 2'b01 << win_id;
          rr_q          <= win_id;
          slot_id_q     <= win_id;
          slot_we_q     <= req_if.we[win_id];
          slot_en_a_q   <= req_if.en_a[win_id];
          slot_en_b_q   <= req_if.en_b[win_id];
          slot_addr_a_q <= win_id ? req_if.addr_a[ADDR_BITS +: ADDR_BITS]
                                  : req_if.addr_a[0 +: ADDR_BITS];
          slot_addr_b_q <= win_id ? req_if.addr_b[ADDR_BITS +: ADDR_BITS]
                                  : req_if.addr_b[0 +: ADDR_BITS];
          slot_wdata_q  <= win_id ? req_if.wdata[WIDTH +: WIDTH]
                                  : req_if.wdata[0 +: WIDTH];
        end
      end

      // Idle slots leave every array signal at its cleared value.
      if (busy_q) begin
        if (phase_d == 4'd2) begin
          word_a_q <= slot_en_a_q ? (WORDS'(1) << slot_addr_a_q) : '0;
          word_b_q <= slot_en_b_q ? (WORDS'(1) << slot_addr_b_q) : '0;
        end
        if (phase_d == 4'd4) din_q <= slot_we_q ? slot_wdata_q : '0;
        if (!slot_we_q && (phase_d == 4'd6 || phase_d == 4'd7)) read_en_q <= 1'b1;
        if (slot_we_q && phase_d == 4'd8) write_en_q <= 1'b1;
        // Array data is sampled at the end of ph7, after two ReadEn cycles.
        if (!slot_we_q && phase_d == 4'd8) begin
          rdata_a_q <= outA_i;
          rdata_b_q <= outB_i;
          rvalid_q  <= 2'b01 << slot_id_q;
        end
      end
    end
  end

  assign req_if.gnt     = gnt_q;
  assign req_if.rvalid  = rvalid_q;
  assign req_if.rdata_a = rdata_a_q;
  assign req_if.rdata_b = rdata_b_q;
  assign wordA_o        = word_a_q;
  assign wordB_o        = word_b_q;
  assign ReadEn_o       = read_en_q;
  assign WriteEn_o      = write_en_q;
  assign din_o          = din_q;
  assign phase_o        = phase_q;
  assign busy_o         = busy_q;

endmodule
